instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
// - Fetch stage upstream of Program_memory: owns the program counter, drives its 8-bit address and samples the combinational 17-bit prog_data.
// - Holds the fetched word in an instruction register and hands it to decode over a valid/ready handshake.
// - Handles backpressure, PC redirects from execute and address wrap-around.
// PARAMETERS
// - ADDR_W    8        program address width (PC width)
// - INSTR_W   17       instruction width
// - OPC_W     5        opcode field width; opcode = instr[INSTR_W-1 -: OPC_W]
// - RESET_PC  8'h00    PC value loaded on reset
// PORTS
// - clk              in   1        single clock, rising edge
// - reset            in   1        asynchronous, active-high reset
// - fetch_en         in   1        1 = fetching allowed
// - pc_addr          out  ADDR_W   address to Program_memory (registered PC)
// - prog_data        in   INSTR_W  instruction at pc_addr (same cycle, combinational)
// - redirect_valid   in   1        execute requests PC change
// - redirect_target  in   ADDR_W   new PC
// - br_resume        in   1        control-flow op resolved not-taken (used only with macro)
// - ir_valid         out  1        ir_data/ir_pc valid for decode
// - ir_ready         in   1        decode accepts this cycle
// - ir_data          out  INSTR_W  fetched instruction
// - ir_pc            out  ADDR_W   address of ir_data
// BEHAVIOUR
// - Reset (async, immediate): pc=RESET_PC, ir_valid=0, ir_data=0 (NOP), ir_pc=0, state=IDLE.
// - States: IDLE, RUN, WAIT_BR (WAIT_BR reachable only with macro).
// - IDLE: no loads. -> RUN on edge with fetch_en=1. First load is on the following edge, so ir_valid rises 2 edges after fetch_en is first sampled high.
// - RUN, fetch_en=0: -> IDLE. The held ir_valid word stays until consumed.
// - Load condition: state=RUN, fetch_en=1, !redirect_valid, (!ir_valid || ir_ready).
// - On load: ir_data<=prog_data, ir_pc<=pc, ir_valid<=1, pc<=pc+1.
// - ir_valid && ir_ready with no load that edge: ir_valid<=0.
// - Stall (ir_valid && !ir_ready): ir_data, ir_pc and pc all hold. Zero bubbles at full throughput (1 instr/cycle).
// - Redirect (highest priority, any state except reset):
//   - pc<=redirect_target and ir_valid<=0; the word being presented is squashed even if ir_ready=1.
//   - Next state: RUN if fetch_en=1, else IDLE.
//   - First instruction from target appears one edge later.
// - PC arithmetic: modulo 2^ADDR_W, so 8'hFF+1 = 8'h00. No overflow flag.
// - Simultaneous redirect and br_resume: redirect wins.
// - Reset mid-stall or mid-WAIT_BR: all state is discarded; no partial output.
// - pc_addr = pc at all times, registered; never glitches combinationally from inputs.
// CONFIGURATION
// - Macro FETCH_BRANCH_HOLD_EN.
// - Defined: a load whose opcode is JML(00010), JMP(00011), JMR(00111), BZ(01011) or BNZ(10011) moves RUN -> WAIT_BR.
//   - WAIT_BR: no loads; pc holds at op_pc+1; the control-flow word is still delivered normally.
//   - redirect_valid -> RUN with pc=target. br_resume -> RUN, fetch continues at pc.
//   - fetch_en=0 in WAIT_BR does not leave WAIT_BR.
// - Undefined: no opcode inspection. Fetch continues sequentially (speculative). Wrong-path words are removed only by redirect squash. br_resume is ignored.
// TESTING
// - Straight line: reset 2 cyc, fetch_en=1, ir_ready=1, ROM addr0..5 -> ir_pc 0,1,2,3 on consecutive edges, ir_data matches ROM, first ir_valid 2 edges after fetch_en.
// - Backpressure: ir_ready=0 for 3 cyc while ir_pc=2 -> ir_data/ir_pc stable, pc_addr=3; ir_ready=1 -> ir_pc=3 on next edge.
// - Redirect: redirect_valid, target=8'h40, while ir_valid=1 and ir_ready=1 -> next edge ir_valid=0, pc_addr=8'h40; following edge ir_pc=8'h40.
// - Wrap: redirect to 8'hFE -> ir_pc FE, FF, 00, 01 on consecutive loads.
// - Async reset asserted between edges during a stall -> immediately ir_valid=0, pc_addr=RESET_PC, ir_data=0; first ir_valid after release is the 2nd edge.
// - FETCH_BRANCH_HOLD_EN defined, JMR at addr 5:
//   - ir_pc=5 delivered, pc_addr holds 6, no ir_valid for 4 cyc.
//   - br_resume -> ir_pc=6 next edge; redirect target 0 instead -> ir_pc=0.
//   - Macro undefined: ir_pc=6 follows 5 immediately.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Fetch stage that owns the PC, reads Program_memory combinationally
//            and presents one instruction per cycle to decode (valid/ready).
//            Optional macro FETCH_BRANCH_HOLD_EN stalls fetch after a
//            control-flow opcode until execute resolves it.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 17,
    parameter int                OPC_W    = 5,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_en,
    output logic [ADDR_W-1:0]  pc_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    input  logic               br_resume,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic [INSTR_W-1:0] ir_data,
    output logic [ADDR_W-1:0]  ir_pc
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        WAIT_BR = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ADDR_W-1:0]    r_pc;
    logic [ADDR_W-1:0]    w_pc_nxt;
    logic                 r_ir_valid;
    logic                 w_ir_valid_nxt;
    logic [INSTR_W-1:0]   r_ir_data;
    logic [INSTR_W-1:0]   w_ir_data_nxt;
    logic [ADDR_W-1:0]    r_ir_pc;
    logic [ADDR_W-1:0]    w_ir_pc_nxt;
    logic                 w_load;
    logic                 w_is_branch;

`ifdef FETCH_BRANCH_HOLD_EN
    localparam logic [OPC_W-1:0] c_OPC_JML = OPC_W'(5'b00010);
    localparam logic [OPC_W-1:0] c_OPC_JMP = OPC_W'(5'b00011);
    localparam logic [OPC_W-1:0] c_OPC_JMR = OPC_W'(5'b00111);
    localparam logic [OPC_W-1:0] c_OPC_BZ  = OPC_W'(5'b01011);
    localparam logic [OPC_W-1:0] c_OPC_BNZ = OPC_W'(5'b10011);

    logic [OPC_W-1:0] w_opcode;
    assign w_opcode    = prog_data[INSTR_W-1 -: OPC_W];
    assign w_is_branch = (w_opcode == c_OPC_JML) || (w_opcode == c_OPC_JMP) ||
                         (w_opcode == c_OPC_JMR) || (w_opcode == c_OPC_BZ)  ||
                         (w_opcode == c_OPC_BNZ);
`else
    // Speculative sequential fetch: wrong-path words are killed by redirect.
    assign w_is_branch = 1'b0;
`endif

    // A new word may enter the IR only when the current one is gone or leaving.
    assign w_load = (r_state == RUN) && fetch_en && !redirect_valid &&
                    (!r_ir_valid || ir_ready);

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_ir_valid_nxt = r_ir_valid;
        w_ir_data_nxt  = r_ir_data;
        w_ir_pc_nxt    = r_ir_pc;

        if (redirect_valid) begin
            // Redirect squashes the presented word even if decode takes it.
            w_pc_nxt       = redirect_target;
            w_ir_valid_nxt = 1'b0;
            w_state_nxt    = fetch_en ? RUN : IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (fetch_en) begin
                        w_state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (!fetch_en) begin
                        w_state_nxt = IDLE;
                    end else if (w_load && w_is_branch) begin
                        w_state_nxt = WAIT_BR;
                    end
                end
                WAIT_BR: begin
                    if (br_resume) begin
                        w_state_nxt = RUN;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase

            if (w_load) begin
                w_ir_data_nxt  = prog_data;
                w_ir_pc_nxt    = r_pc;
                w_ir_valid_nxt = 1'b1;
                w_pc_nxt       = r_pc + ADDR_W'(1);
            end else if (r_ir_valid && ir_ready) begin
                w_ir_valid_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_ir_valid <= 1'b0;
            r_ir_data  <= '0;
            r_ir_pc    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_ir_valid <= w_ir_valid_nxt;
            r_ir_data  <= w_ir_data_nxt;
            r_ir_pc    <= w_ir_pc_nxt;
        end
    end

    assign pc_addr  = r_pc;
    assign ir_valid = r_ir_valid;
    assign ir_data  = r_ir_data;
    assign ir_pc    = r_ir_pc;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Directed self-checking bench for instr_fetch_unit with a modelled
//            combinational program ROM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic [7:0]  pc_addr;
    logic [16:0] prog_data;
    logic        redirect_valid;
    logic [7:0]  redirect_target;
    logic        br_resume;
    logic        ir_valid;
    logic        ir_ready;
    logic [16:0] ir_data;
    logic [7:0]  ir_pc;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    // ROM: opcode 00001 everywhere except a JMR (00111) at address 5.
    function automatic logic [16:0] rom_word(input logic [7:0] a);
        logic [4:0] opc;
        opc = (a == 8'h05) ? 5'b00111 : 5'b00001;
        return {opc, 4'b1010, a};
    endfunction

    assign prog_data = rom_word(pc_addr);

    instr_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_en        (fetch_en),
        .pc_addr         (pc_addr),
        .prog_data       (prog_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .br_resume       (br_resume),
        .ir_valid        (ir_valid),
        .ir_ready        (ir_ready),
        .ir_data         (ir_data),
        .ir_pc           (ir_pc)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; fetch_en = 1'b0; ir_ready = 1'b0;
        redirect_valid = 1'b0; redirect_target = 8'h00; br_resume = 1'b0;
        tick; tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; fetch_en = 1'b0; ir_ready = 1'b0;
        redirect_valid = 1'b0; redirect_target = 8'h00; br_resume = 1'b0;
        tick; tick;
        tests++; if (pc_addr !== 8'h00) begin failed++; $display("FAIL reset_pc: got %h exp 00", pc_addr); end
        tests++; if (ir_valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b exp 0", ir_valid); end
        tests++; if (ir_data !== 17'h0) begin failed++; $display("FAIL reset_data: got %h exp 0", ir_data); end
        tests++; if (ir_pc !== 8'h00) begin failed++; $display("FAIL reset_irpc: got %h exp 00", ir_pc); end
        reset = 1'b0;
        tick; tick;
        tests++; if (ir_valid !== 1'b0) begin failed++; $display("FAIL idle_valid: got %b exp 0", ir_valid); end
        tests++; if (pc_addr !== 8'h00) begin failed++; $display("FAIL idle_pc: got %h exp 00", pc_addr); end
    endtask

    task automatic test_straight_line;
        do_reset;
        fetch_en = 1'b1; ir_ready = 1'b1;
        tick;
        tests++; if (ir_valid !== 1'b0) begin failed++; $display("FAIL sl_first_edge_valid: got %b exp 0", ir_valid); end
        for (int k = 0; k < 4; k++) begin
            tick;
            tests++; if (ir_valid !== 1'b1) begin failed++; $display("FAIL sl_valid[%0d]: got %b exp 1", k, ir_valid); end
            tests++; if (ir_pc !== 8'(k)) begin failed++; $display("FAIL sl_irpc[%0d]: got %h exp %h", k, ir_pc, 8'(k)); end
            tests++; if (ir_data !== rom_word(8'(k))) begin failed++; $display("FAIL sl_data[%0d]: got %h exp %h", k, ir_data, rom_word(8'(k))); end
            tests++; if (pc_addr !== 8'(k + 1)) begin failed++; $display("FAIL sl_pc[%0d]: got %h exp %h", k, pc_addr, 8'(k + 1)); end
        end
    endtask

    task automatic test_backpressure;
        do_reset;
        fetch_en = 1'b1; ir_ready = 1'b1;
        tick; tick; tick; tick;
        tests++; if (ir_pc !== 8'h02) begin failed++; $display("FAIL bp_pre_irpc: got %h exp 02", ir_pc); end
        ir_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            tests++; if (ir_valid !== 1'b1) begin failed++; $display("FAIL bp_valid[%0d]: got %b exp 1", k, ir_valid); end
            tests++; if (ir_pc !== 8'h02) begin failed++; $display("FAIL bp_irpc[%0d]: got %h exp 02", k, ir_pc); end
            tests++; if (ir_data !== rom_word(8'h02)) begin failed++; $display("FAIL bp_data[%0d]: got %h exp %h", k, ir_data, rom_word(8'h02)); end
            tests++; if (pc_addr !== 8'h03) begin failed++; $display("FAIL bp_pc[%0d]: got %h exp 03", k, pc_addr); end
        end
        ir_ready = 1'b1;
        tick;
        tests++; if (ir_pc !== 8'h03) begin failed++; $display("FAIL bp_release_irpc: got %h exp 03", ir_pc); end
        tests++; if (ir_valid !== 1'b1) begin failed++; $display("FAIL bp_release_valid: got %b exp 1", ir_valid); end
        tests++; if (pc_addr !== 8'h04) begin failed++; $display("FAIL bp_release_pc: got %h exp 04", pc_addr); end
    endtask

    task automatic test_redirect;
        do_reset;
        fetch_en = 1'b1; ir_ready = 1'b1;
        tick; tick; tick;
        redirect_valid = 1'b1; redirect_target = 8'h40;
        tick;
        redirect_valid = 1'b0;
        tests++; if (ir_valid !== 1'b0) begin failed++; $display("FAIL rd_squash_valid: got %b exp 0", ir_valid); end
        tests++; if (pc_addr !== 8'h40) begin failed++; $display("FAIL rd_pc: got %h exp 40", pc_addr); end
        tick;
        tests++; if (ir_valid !== 1'b1) begin failed++; $display("FAIL rd_tgt_valid: got %b exp 1", ir_valid); end
        tests++; if (ir_pc !== 8'h40) begin failed++; $display("FAIL rd_tgt_irpc: got %h exp 40", ir_pc); end
        tests++; if (ir_data !== rom_word(8'h40)) begin failed++; $display("FAIL rd_tgt_data: got %h exp %h", ir_data, rom_word(8'h40)); end
        tests++; if (pc_addr !== 8'h41) begin failed++; $display("FAIL rd_next_pc: got %h exp 41", pc_addr); end
    endtask

    task automatic test_wrap;
        logic [7:0] exp_pc;
        do_reset;
        fetch_en = 1'b1; ir_ready = 1'b1;
        tick;
        redirect_valid = 1'b1; redirect_target = 8'hFE;
        tick;
        redirect_valid = 1'b0;
        tests++; if (pc_addr !== 8'hFE) begin failed++; $display("FAIL wrap_pc0: got %h exp fe", pc_addr); end
        exp_pc = 8'hFE;
        for (int k = 0; k < 4; k++) begin
            tick;
            tests++; if (ir_pc !== exp_pc) begin failed++; $display("FAIL wrap_irpc[%0d]: got %h exp %h", k, ir_pc, exp_pc); end
            tests++; if (ir_data !== rom_word(exp_pc)) begin failed++; $display("FAIL wrap_data[%0d]: got %h exp %h", k, ir_data, rom_word(exp_pc)); end
            exp_pc = exp_pc + 8'h01;
        end
        tests++; if (pc_addr !== 8'h02) begin failed++; $display("FAIL wrap_pc_end: got %h exp 02", pc_addr); end
    endtask

    task automatic test_async_reset;
        do_reset;
        fetch_en = 1'b1; ir_ready = 1'b1;
        tick; tick; tick;
        ir_ready = 1'b0;
        tick;
        #3;
        reset = 1'b1;
        #1;
        tests++; if (ir_valid !== 1'b0) begin failed++; $display("FAIL ar_valid: got %b exp 0", ir_valid); end
        tests++; if (pc_addr !== 8'h00) begin failed++; $display("FAIL ar_pc: got %h exp 00", pc_addr); end
        tests++; if (ir_data !== 17'h0) begin failed++; $display("FAIL ar_data: got %h exp 0", ir_data); end
        tests++; if (ir_pc !== 8'h00) begin failed++; $display("FAIL ar_irpc: got %h exp 00", ir_pc); end
        ir_ready = 1'b1;
        @(posedge clk);
        #3;
        reset = 1'b0;
        tick;
        tests++; if (ir_valid !== 1'b0) begin failed++; $display("FAIL ar_rel_edge1: got %b exp 0", ir_valid); end
        tick;
        tests++; if (ir_valid !== 1'b1) begin failed++; $display("FAIL ar_rel_edge2: got %b exp 1", ir_valid); end
        tests++; if (ir_pc !== 8'h00) begin failed++; $display("FAIL ar_rel_irpc: got %h exp 00", ir_pc); end
    endtask

    task automatic test_branch_hold;
        do_reset;
        fetch_en = 1'b1; ir_ready = 1'b1;
        tick;
        repeat (6) tick;
        tests++; if (ir_pc !== 8'h05) begin failed++; $display("FAIL br_irpc5: got %h exp 05", ir_pc); end
        tests++; if (ir_data !== rom_word(8'h05)) begin failed++; $display("FAIL br_data5: got %h exp %h", ir_data, rom_word(8'h05)); end
`ifdef FETCH_BRANCH_HOLD_EN
        for (int k = 0; k < 4; k++) begin
            tick;
            tests++; if (ir_valid !== 1'b0) begin failed++; $display("FAIL br_hold_valid[%0d]: got %b exp 0", k, ir_valid); end
            tests++; if (pc_addr !== 8'h06) begin failed++; $display("FAIL br_hold_pc[%0d]: got %h exp 06", k, pc_addr); end
        end
        br_resume = 1'b1;
        tick;
        br_resume = 1'b0;
        tests++; if (pc_addr !== 8'h06) begin failed++; $display("FAIL br_resume_pc: got %h exp 06", pc_addr); end
        tick;
        tests++; if (ir_valid !== 1'b1) begin failed++; $display("FAIL br_resume_valid: got %b exp 1", ir_valid); end
        tests++; if (ir_pc !== 8'h06) begin failed++; $display("FAIL br_resume_irpc: got %h exp 06", ir_pc); end
        do_reset;
        fetch_en = 1'b1; ir_ready = 1'b1;
        tick;
        repeat (6) tick;
        tick;
`else
        br_resume = 1'b1;
        tick;
        br_resume = 1'b0;
        tests++; if (ir_valid !== 1'b1) begin failed++; $display("FAIL br_spec_valid: got %b exp 1", ir_valid); end
        tests++; if (ir_pc !== 8'h06) begin failed++; $display("FAIL br_spec_irpc: got %h exp 06", ir_pc); end
        tests++; if (pc_addr !== 8'h07) begin failed++; $display("FAIL br_spec_pc: got %h exp 07", pc_addr); end
`endif
        redirect_valid = 1'b1; redirect_target = 8'h00;
        tick;
        redirect_valid = 1'b0;
        tests++; if (ir_valid !== 1'b0) begin failed++; $display("FAIL br_rd_valid: got %b exp 0", ir_valid); end
        tests++; if (pc_addr !== 8'h00) begin failed++; $display("FAIL br_rd_pc: got %h exp 00", pc_addr); end
        tick;
        tests++; if (ir_valid !== 1'b1) begin failed++; $display("FAIL br_rd_tgt_valid: got %b exp 1", ir_valid); end
        tests++; if (ir_pc !== 8'h00) begin failed++; $display("FAIL br_rd_tgt_irpc: got %h exp 00", ir_pc); end
    endtask

    initial begin
        test_reset;
        test_straight_line;
        test_backpressure;
        test_redirect;
        test_wrap;
        test_async_reset;
        test_branch_hold;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
